// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle between the operand register file, fp_add_sequencer and writeback.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Parameters:
//    MANT_W   mantissa width (explicit leading 1)
//    EXP_W    exponent width (unsigned, unbiased)
// Signals (direction as seen from the sequencer, i.e. the slave modport):
//    in_valid  in   operand pair valid
//    in_ready  out  sequencer idle and able to capture operands
//    x_exp     in   operand X exponent
//    x_mant    in   operand X mantissa
//    y_exp     in   operand Y exponent
//    y_mant    in   operand Y mantissa
//    out_valid out  result valid, held until out_ready
//    out_ready in   downstream accepts the result
//    q_exp     out  result exponent
//    q_mant    out  result mantissa
//    overflow  out  result saturated, qualified by out_valid
//    busy      out  an operation is in flight
interface fp_add_sequencer_if #(
   parameter int MANT_W = 8,
   parameter int EXP_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [EXP_W-1:0]  x_exp;
   logic [MANT_W-1:0] x_mant;
   logic [EXP_W-1:0]  y_exp;
   logic [MANT_W-1:0] y_mant;
   logic              out_valid;
   logic              out_ready;
   logic [EXP_W-1:0]  q_exp;
   logic [MANT_W-1:0] q_mant;
   logic              overflow;
   logic              busy;

   // Operand source / result sink side.
   modport master (
      output in_valid, x_exp, x_mant, y_exp, y_mant, out_ready,
      input  in_ready, out_valid, q_exp, q_mant, overflow, busy
   );

   // Sequencer side.
   modport slave (
      input  in_valid, x_exp, x_mant, y_exp, y_mant, out_ready,
      output in_ready, out_valid, q_exp, q_mant, overflow, busy
   );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle unsigned-magnitude floating-point adder: compare/swap, align, add, normalize.
// Latency: result valid on the 5th rising edge counting the accepting edge (IDLE->COMPARE->ALIGN->ADD->NORM->DONE).
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//    clk     in   single clock, rising edge
//    reset   in   asynchronous, active-high; aborts any operation in flight
//    bus     fp_add_sequencer_if.slave (operand handshake, result handshake, busy)
// Configuration macro:
//    FP_ADD_ROUND_EN  defined: guard/sticky tracking and round-to-nearest-even in NORM
//                     undefined: shifted-out bits are truncated
module fp_add_sequencer #(
   parameter int MANT_W = 8,
   parameter int EXP_W  = 4
) (
   input logic               clk,
   input logic               reset,
   fp_add_sequencer_if.slave bus
);

   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef struct packed {
      logic [EXP_W-1:0]  e;
      logic [MANT_W-1:0] m;
   } operand_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   // Captured operands.
   operand_t x_op, y_op;

   // COMPARE results: A is the larger-exponent operand.
   logic [EXP_W-1:0]  a_exp;
   logic [MANT_W-1:0] a_mant;
   logic [MANT_W-1:0] b_mant;
   logic [EXP_W-1:0]  diff;

   // ALIGN / ADD results.
   logic [MANT_W-1:0] b_al;
   logic [MANT_W:0]   sum_q;

   // Result registers, held through DONE and beyond until the next NORM.
   logic [EXP_W-1:0]  q_exp_r;
   logic [MANT_W-1:0] q_mant_r;
   logic              ovf_r;

   // Combinational next values per stage.
   operand_t          x_eff, y_eff, a_nxt, b_nxt;
   logic [EXP_W-1:0]  diff_nxt;
   logic [MANT_W-1:0] b_al_nxt;
   logic [MANT_W:0]   sum_nxt;
   logic              n_carry;
   logic [EXP_W-1:0]  n_exp;
   logic [MANT_W-1:0] n_mant;
   logic              n_ovf;

`ifdef FP_ADD_ROUND_EN
   logic              guard_q, sticky_q;
   logic              guard_nxt, sticky_nxt;
   logic              n_guard, n_sticky, n_inc;
   logic [MANT_W:0]   n_rnd;
`endif

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (bus.in_valid) state_nxt = S_COMPARE;
         S_COMPARE: state_nxt = S_ALIGN;
         S_ALIGN:   state_nxt = S_ADD;
         S_ADD:     state_nxt = S_NORM;
         S_NORM:    state_nxt = S_DONE;
         S_DONE:    if (bus.out_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.q_exp     = q_exp_r;
   assign bus.q_mant    = q_mant_r;
   assign bus.overflow  = ovf_r;

   // ------------------------------------------------------------------
   // COMPARE: a zero mantissa means a zero operand whose exponent must not
   // win the swap, so its exponent is forced to 0 first.
   // ------------------------------------------------------------------
   always_comb begin
      x_eff = x_op;
      y_eff = y_op;
      if (x_op.m == '0) x_eff.e = '0;
      if (y_op.m == '0) y_eff.e = '0;
      // Ties keep X as A.
      if (y_eff.e > x_eff.e) begin
         a_nxt = y_eff;
         b_nxt = x_eff;
      end else begin
         a_nxt = x_eff;
         b_nxt = y_eff;
      end
      diff_nxt = a_nxt.e - b_nxt.e;
   end

   // ------------------------------------------------------------------
   // ALIGN: shifts of MANT_W or more flush B entirely.
   // ------------------------------------------------------------------
   always_comb begin
      b_al_nxt = '0;
`ifdef FP_ADD_ROUND_EN
      guard_nxt  = 1'b0;
      sticky_nxt = 1'b0;
`endif
      if (int'(diff) < MANT_W) begin
         b_al_nxt = b_mant >> diff;
`ifdef FP_ADD_ROUND_EN
         // Bit diff-1 is the last one shifted out (guard); everything below
         // it folds into sticky.
         for (int i = 0; i < MANT_W; i++) begin
            if (i + 1 == int'(diff)) begin
               guard_nxt = b_mant[i];
            end else if (i + 1 < int'(diff)) begin
               sticky_nxt = sticky_nxt | b_mant[i];
            end
         end
`endif
      end else begin
`ifdef FP_ADD_ROUND_EN
         sticky_nxt = |b_mant;
`endif
      end
   end

   // ------------------------------------------------------------------
   // ADD
   // ------------------------------------------------------------------
   assign sum_nxt = {1'b0, a_mant} + {1'b0, b_al};

   // ------------------------------------------------------------------
   // NORM: at most one right shift is ever needed since both mantissas fit
   // in MANT_W bits. Any exponent increment past EXP_MAX saturates.
   // ------------------------------------------------------------------
   always_comb begin
      n_carry = sum_q[MANT_W];
      n_mant  = n_carry ? sum_q[MANT_W:1] : sum_q[MANT_W-1:0];
      n_exp   = a_exp;
      n_ovf   = 1'b0;
`ifdef FP_ADD_ROUND_EN
      n_guard  = n_carry ? sum_q[0] : guard_q;
      n_sticky = n_carry ? (sticky_q | guard_q) : sticky_q;
      n_inc    = n_guard & (n_sticky | n_mant[0]);
      n_rnd    = {1'b0, n_mant} + {{MANT_W{1'b0}}, n_inc};
      if (n_rnd[MANT_W]) begin
         // Rounding carried out of an all-ones mantissa: renormalize to 100..0.
         // A carry shift always leaves guard=0 when the mantissa is all ones,
         // so the two increments never coincide.
         n_mant  = {1'b1, {(MANT_W-1){1'b0}}};
         n_carry = 1'b1;
      end else begin
         n_mant = n_rnd[MANT_W-1:0];
      end
`endif
      if (n_carry) begin
         if (a_exp == EXP_MAX) begin
            n_ovf  = 1'b1;
            n_exp  = EXP_MAX;
            n_mant = '1;
         end else begin
            n_exp = a_exp + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers, each loaded only in the state that owns it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_op     <= '0;
         y_op     <= '0;
         a_exp    <= '0;
         a_mant   <= '0;
         b_mant   <= '0;
         diff     <= '0;
         b_al     <= '0;
         sum_q    <= '0;
         q_exp_r  <= '0;
         q_mant_r <= '0;
         ovf_r    <= 1'b0;
`ifdef FP_ADD_ROUND_EN
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  x_op <= {bus.x_exp, bus.x_mant};
                  y_op <= {bus.y_exp, bus.y_mant};
               end
            end
            S_COMPARE: begin
               a_exp  <= a_nxt.e;
               a_mant <= a_nxt.m;
               b_mant <= b_nxt.m;
               diff   <= diff_nxt;
            end
            S_ALIGN: begin
               b_al <= b_al_nxt;
`ifdef FP_ADD_ROUND_EN
               guard_q  <= guard_nxt;
               sticky_q <= sticky_nxt;
`endif
            end
            S_ADD: begin
               sum_q <= sum_nxt;
            end
            S_NORM: begin
               q_exp_r  <= n_exp;
               q_mant_r <= n_mant;
               ovf_r    <= n_ovf;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer: directed vectors, randomized ops
// against an arithmetic reference model, handshake hold, mid-op reset, back-to-back.
// Latency is counted in rising edges including the accepting edge.
module tb_fp_add_sequencer;

   localparam int MANT_W = 8;
   localparam int EXP_W  = 4;
   localparam int EMAX   = (1 << EXP_W) - 1;
   localparam int MMAX   = (1 << MANT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   fp_add_sequencer_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

   fp_add_sequencer #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Reference model: exact integer arithmetic from the addition rules.
   function automatic void ref_add(input int xe, input int xm, input int ye, input int ym,
                                   output int qe, output int qm, output bit qo);
      int ae, am, be, bm, d, bal, sum, e, m;
      bit g, s;
      if (xm == 0) xe = 0;
      if (ym == 0) ye = 0;
      if (ye > xe) begin ae = ye; am = ym; be = xe; bm = xm; end
      else         begin ae = xe; am = xm; be = ye; bm = ym; end
      d = ae - be;
      g = 0;
      s = 0;
      if (d >= MANT_W) begin
         bal = 0;
         s   = (bm != 0);
      end else begin
         bal = bm / (1 << d);
         if (d > 0) begin
            g = ((bm / (1 << (d - 1))) % 2) == 1;
            s = (bm % (1 << (d - 1))) != 0;
         end
      end
      sum = am + bal;
      e   = ae;
      m   = sum;
      if (sum > MMAX) begin
         s = s | g;
         g = (sum % 2) == 1;
         m = sum / 2;
         e = e + 1;
      end
`ifdef FP_ADD_ROUND_EN
      if (g && (s || (m % 2 == 1))) m = m + 1;
      if (m > MMAX) begin
         m = 1 << (MANT_W - 1);
         e = e + 1;
      end
`endif
      qo = 0;
      if (e > EMAX) begin
         qo = 1;
         e  = EMAX;
         m  = MMAX;
      end
      qe = e;
      qm = m;
   endfunction

   function automatic int rnd_mant();
      if ($urandom_range(0, 7) == 0) return 0;
      return int'($urandom_range(128, 255));
   endfunction

   function automatic int rnd_exp();
      return int'($urandom_range(0, EMAX));
   endfunction

   // Runs one operation from an idle-ish point (#1 after an edge).
   task automatic do_op(input int xe, input int xm, input int ye, input int ym, input int rdy_dly,
                        output int qe, output int qm, output bit qo, output int lat);
      int n;
      bus.x_exp    = xe[EXP_W-1:0];
      bus.x_mant   = xm[MANT_W-1:0];
      bus.y_exp    = ye[EXP_W-1:0];
      bus.y_mant   = ym[MANT_W-1:0];
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (n >= 20) begin
         n_err++;
         $display("FAIL accept_wait: in_ready got %b, required 1 within 20 clocks", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      qe = int'(bus.q_exp);
      qm = int'(bus.q_mant);
      qo = bus.overflow;
      for (int i = 0; i < rdy_dly; i++) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL release: out_valid/in_ready got %b/%b, required 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.q_exp !== '0 || bus.q_mant !== '0 || bus.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: rdy=%b vld=%b busy=%b q=(%0d,%h) ovf=%b, required 1 0 0 (0,00) 0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.q_exp, bus.q_mant, bus.overflow);
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: rdy=%b busy=%b vld=%b, required 1 0 0",
                  bus.in_ready, bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_directed();
      int dxe[8] = '{3, 2, 1, 12, 15, 9, 1, 0};
      int dxm[8] = '{'h80, 'hC0, 'h80, 'h90, 'h80, 'h00, 'h80, 'hFF};
      int dye[8] = '{1, 2, 4, 2, 15, 5, 0, 0};
      int dym[8] = '{'h80, 'hC0, 'h80, 'hFF, 'h80, 'h00, 'h83, 'hFF};
      int dqe[8] = '{3, 3, 4, 12, 15, 0, 1, 1};
      int dqm[8] = '{'hA0, 'hC0, 'h90, 'h90, 'hFF, 'h00, 'hC1, 'hFF};
      bit dqo[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      int qe, qm, lat;
      bit qo;
`ifdef FP_ADD_ROUND_EN
      dqm[6] = 'hC2;
`endif
      for (int i = 0; i < 8; i++) begin
         do_op(dxe[i], dxm[i], dye[i], dym[i], i % 3, qe, qm, qo, lat);
         n_cmp++;
         if (qe != dqe[i] || qm != dqm[i] || qo != dqo[i]) begin
            n_err++;
            $display("FAIL directed_%0d: got q=(%0d,%h) ovf=%b, required q=(%0d,%h) ovf=%b",
                     i, qe, qm, qo, dqe[i], dqm[i], dqo[i]);
         end
         n_cmp++;
         if (lat != 5) begin
            n_err++;
            $display("FAIL directed_latency_%0d: got %0d clocks, required 5", i, lat);
         end
      end
   endtask

   task automatic test_random();
      int xe, xm, ye, ym, qe, qm, lat, ee, em;
      bit qo, eo;
      for (int i = 0; i < 40; i++) begin
         xe = rnd_exp(); xm = rnd_mant();
         ye = (i % 2 == 0) ? rnd_exp() : int'($urandom_range(0, 3)) + (xe > 11 ? 11 : xe);
         ym = rnd_mant();
         ref_add(xe, xm, ye, ym, ee, em, eo);
         do_op(xe, xm, ye, ym, int'($urandom_range(0, 3)), qe, qm, qo, lat);
         n_cmp++;
         if (qe != ee || qm != em || qo != eo || lat != 5) begin
            n_err++;
            $display("FAIL random_%0d: (%0d,%h)+(%0d,%h) got q=(%0d,%h) ovf=%b lat=%0d, required q=(%0d,%h) ovf=%b lat=5",
                     i, xe, xm, ye, ym, qe, qm, qo, lat, ee, em, eo);
         end
      end
   endtask

   task automatic test_hold();
      int n, he, hm, bad, qe, qm, lat, ee, em;
      bit ho, qo, eo;
      bus.x_exp = 4'd2; bus.x_mant = 8'hC0; bus.y_exp = 4'd2; bus.y_mant = 8'hC0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      // Busy now: offer a different pair that must be ignored.
      bus.x_exp = 4'd7; bus.x_mant = 8'h80; bus.y_exp = 4'd7; bus.y_mant = 8'h80;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      he = int'(bus.q_exp); hm = int'(bus.q_mant); ho = bus.overflow;
      n_cmp++;
      if (he != 3 || hm != 'hC0 || ho != 1'b0) begin
         n_err++;
         $display("FAIL hold_result: got q=(%0d,%h) ovf=%b, required q=(3,c0) ovf=0", he, hm, ho);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
             int'(bus.q_exp) != he || int'(bus.q_mant) != hm || bus.overflow !== ho) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL hold_stable: got %0d unstable clocks, required 0", bad);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL hold_ignored_input: busy=%b rdy=%b, required 0 1", bus.busy, bus.in_ready);
      end
      ref_add(5, 'hF0, 3, 'hB5, ee, em, eo);
      do_op(5, 'hF0, 3, 'hB5, 0, qe, qm, qo, lat);
      n_cmp++;
      if (qe != ee || qm != em || qo != eo) begin
         n_err++;
         $display("FAIL hold_next_op: got q=(%0d,%h) ovf=%b, required q=(%0d,%h) ovf=%b",
                  qe, qm, qo, ee, em, eo);
      end
   endtask

   task automatic test_reset_mid();
      int seen, qe, qm, lat, xe, xm, ye, ym, ee, em;
      bit qo, eo;
      bus.x_exp = 4'd15; bus.x_mant = 8'h80; bus.y_exp = 4'd15; bus.y_mant = 8'h80;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_busy: got %b, required 1", bus.busy);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.q_exp !== '0 || bus.q_mant !== '0 || bus.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_outputs: rdy=%b vld=%b busy=%b q=(%0d,%h) ovf=%b, required 1 0 0 (0,00) 0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.q_exp, bus.q_mant, bus.overflow);
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL midreset_no_result: got %0d active clocks, required 0", seen);
      end
      xe = rnd_exp(); xm = int'($urandom_range(128, 255));
      ye = rnd_exp(); ym = int'($urandom_range(128, 255));
      ref_add(xe, xm, ye, ym, ee, em, eo);
      do_op(xe, xm, ye, ym, 1, qe, qm, qo, lat);
      n_cmp++;
      if (qe != ee || qm != em || qo != eo || lat != 5) begin
         n_err++;
         $display("FAIL midreset_next_op: got q=(%0d,%h) ovf=%b lat=%0d, required q=(%0d,%h) ovf=%b lat=5",
                  qe, qm, qo, lat, ee, em, eo);
      end
   endtask

   task automatic test_back_to_back();
      int eq_e[$], eq_m[$], acc_cyc[$];
      bit eq_o[$];
      int n_acc, n_res, xe, xm, ye, ym, ee, em, pe, pm;
      bit eo, po, acc;
      n_acc = 0;
      n_res = 0;
      xe = rnd_exp(); xm = rnd_mant(); ye = rnd_exp(); ym = rnd_mant();
      bus.x_exp = xe[EXP_W-1:0]; bus.x_mant = xm[MANT_W-1:0];
      bus.y_exp = ye[EXP_W-1:0]; bus.y_mant = ym[MANT_W-1:0];
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int cyc = 0; cyc < 60 && n_res < 4; cyc++) begin
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            ref_add(xe, xm, ye, ym, ee, em, eo);
            eq_e.push_back(ee); eq_m.push_back(em); eq_o.push_back(eo);
            acc_cyc.push_back(cyc);
            n_acc++;
            if (n_acc < 4) begin
               xe = rnd_exp(); xm = rnd_mant(); ye = rnd_exp(); ym = rnd_mant();
               bus.x_exp = xe[EXP_W-1:0]; bus.x_mant = xm[MANT_W-1:0];
               bus.y_exp = ye[EXP_W-1:0]; bus.y_mant = ym[MANT_W-1:0];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (bus.out_valid === 1'b1) begin
            n_cmp++;
            if (eq_e.size() == 0) begin
               n_err++;
               $display("FAIL b2b_unexpected: got result (%0d,%h), required none pending", bus.q_exp, bus.q_mant);
            end else begin
               pe = eq_e.pop_front(); pm = eq_m.pop_front(); po = eq_o.pop_front();
               if (int'(bus.q_exp) != pe || int'(bus.q_mant) != pm || bus.overflow !== po) begin
                  n_err++;
                  $display("FAIL b2b_result_%0d: got q=(%0d,%h) ovf=%b, required q=(%0d,%h) ovf=%b",
                           n_res, bus.q_exp, bus.q_mant, bus.overflow, pe, pm, po);
               end
            end
            n_res++;
         end
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      n_cmp++;
      if (n_res != 4) begin
         n_err++;
         $display("FAIL b2b_count: got %0d results, required 4", n_res);
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         n_cmp++;
         if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
            n_err++;
            $display("FAIL b2b_spacing_%0d: got %0d clocks, required 6", i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x_exp     = '0;
      bus.x_mant    = '0;
      bus.y_exp     = '0;
      bus.y_mant    = '0;
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
